// File: rtl/user_project_la_loopback_if.sv
// user_project_la_loopback_if: logic-analyzer bank bus between management core and loopback block
interface user_project_la_loopback_if #(
  parameter int BANK_W  = 32,
  parameter int N_BANKS = 4
);
  logic [N_BANKS*BANK_W-1:0] la_data_in;
  logic [N_BANKS*BANK_W-1:0] la_oenb;
  logic [2*N_BANKS-1:0]      mode_i;
  logic [N_BANKS-1:0]        capture_i;
  logic [N_BANKS-1:0]        chg_irq_o;
  modport master (output la_data_in, la_oenb, mode_i, capture_i, input chg_irq_o);
  modport slave  (input la_data_in, la_oenb, mode_i, capture_i, output chg_irq_o);
endinterface

// File: rtl/user_project_la_loopback.sv
// user_project_la_loopback: per-bank LA loopback from the partner bank with pass/reg/hold/count modes
module user_project_la_loopback #(
  parameter int BANK_W  = 32,
  parameter int N_BANKS = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n,
  user_project_la_loopback_if.slave   bus,
  output wire  [N_BANKS*BANK_W-1:0]   la_data_out
);
  logic [N_BANKS*BANK_W-1:0] v;
  logic                      valid;
  // valid masks the change detector until s_i holds a real sample
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) valid <= 1'b0;
    else           valid <= 1'b1;
  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    logic [BANK_W-1:0] src, r, s, nxt;
    logic [1:0]        md;
    logic              cap, irq;
    assign src = bus.la_data_in[(g ^ 1)*BANK_W +: BANK_W];
    assign md  = bus.mode_i[2*g +: 2];
    assign cap = bus.capture_i[g];
    // capture wins in HOLD/COUNT; PASS/REG always track the partner
    assign nxt = (md[1] && !cap) ? (md[0] ? r + 1'b1 : r) : src;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n)
      if (!wb_rst_n) begin
        r   <= '0;
        s   <= '0;
        irq <= 1'b0;
      end else begin
        r   <= nxt;
        s   <= src;
        irq <= valid && (src != s);
      end
    assign v[g*BANK_W +: BANK_W] = (md == 2'b00) ? src : r;
    assign bus.chg_irq_o[g]      = irq;
  end
  for (genvar b = 0; b < N_BANKS*BANK_W; b++) begin : g_bit
    assign la_data_out[b] = bus.la_oenb[b] ? v[b] : 1'bz;
  end
endmodule

// File: doc/user_project_la_loopback.md
USER_PROJECT_LA_LOOPBACK -- requirements
Module: user_project_la_loopback

Interface
REQ-001 SHALL provide parameter BANK_W, default 32, bits per logic-analyzer bank.
REQ-002 SHALL provide parameter N_BANKS, default 4, bank count; SHALL be even and at least 2.
REQ-003 SHALL provide wb_clk_i  input  1  single clock, all state rising-edge.
REQ-004 SHALL provide wb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide la_data_in  input  N_BANKS*BANK_W  LA data from the management core.
REQ-006 SHALL provide la_oenb  input  N_BANKS*BANK_W  per-bit output-enable-bar; high means the block drives that bit.
REQ-007 SHALL provide la_data_out  output  N_BANKS*BANK_W  LA data to the management core.
REQ-008 SHALL provide mode_i  input  2*N_BANKS  per-bank mode; bank i uses bits [2i+1:2i].
REQ-009 SHALL provide capture_i  input  N_BANKS  per-bank load strobe, sampled on the clock edge.
REQ-010 SHALL provide chg_irq_o  output  N_BANKS  per-bank change-detect pulse.

Function
REQ-011 Bank i partner SHALL be p(i) = i XOR 1; src_i = la_data_in bank p(i).
REQ-012 Each la_data_out bit SHALL be high-impedance when its la_oenb bit is 0, else the matching bit of bank value v_i.
REQ-013 Each bank SHALL hold a BANK_W register r_i.
REQ-014 Mode 00 PASS: v_i = src_i combinationally, zero latency; r_i loads src_i every cycle.
REQ-015 Mode 01 REG: v_i = r_i; r_i loads src_i every cycle; latency exactly 1 cycle.
REQ-016 Mode 10 HOLD: v_i = r_i; r_i loads src_i on an edge with capture_i[i]=1, otherwise holds.
REQ-017 Mode 11 COUNT: v_i = r_i; r_i increments by 1 every cycle, modulo 2^BANK_W; all-ones wraps to 0.
REQ-018 COUNT with capture_i[i]=1 SHALL load src_i instead of incrementing; load has priority.
REQ-019 In modes 00 and 01, capture_i[i] SHALL be ignored.
REQ-020 A mode change SHALL NOT clear r_i; the new mode's rule applies from the first edge after mode_i changes (e.g. PASS->HOLD holds the last src_i; ->COUNT continues from the current r_i).
REQ-021 Each bank SHALL keep a previous-sample register s_i, loaded with src_i every cycle, regardless of mode.
REQ-022 chg_irq_o[i] SHALL be registered and high for exactly one cycle after any edge where src_i != s_i and valid=1.
REQ-023 A valid flag SHALL be 0 out of reset and set to 1 on the first edge after reset release; this suppresses a spurious first-cycle interrupt.
REQ-024 Banks SHALL operate independently; simultaneous capture, mode change and src change on different banks SHALL not interact.

Reset
REQ-025 While wb_rst_n=0: every r_i=0, s_i=0, valid=0, chg_irq_o=0. In PASS mode la_data_out still reflects src_i (combinational); in other modes driven bits read 0.
REQ-026 Asserting reset mid-count or mid-hold SHALL clear state immediately, without waiting for a clock edge.
REQ-027 After release, the first active edge SHALL follow REQ-014..REQ-023 normally.

Verification
REQ-028 Default params, mode_i=0, la_oenb all 1, la_data_in=0x44444444_33333333_22222222_11111111 -> la_data_out=0x33333333_44444444_11111111_22222222 in the same cycle.
REQ-029 Bank 0 in REG, bank 1 input steps 0->0xDEADBEEF -> bank 0 out changes exactly 1 cycle later; chg_irq_o[0] pulses once, 1 cycle after the step.
REQ-030 Bank 2 in HOLD, capture pulse with bank 3 input=0xA5A5A5A5, then bank 3 input changes to 0 -> bank 2 out stays 0xA5A5A5A5.
REQ-031 Bank 1 in COUNT, capture loads 0xFFFFFFFE -> out 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 on successive cycles.
REQ-032 la_oenb bank 0 = 0x0000FFFF in PASS -> bits [31:16] high-impedance, bits [15:0] = bank 1 input [15:0].
REQ-033 Reset asserted asynchronously mid-COUNT at value 0x1234 -> out 0 before the next edge, chg_irq_o=0; no interrupt on the first edge after release even with nonzero inputs.
